counter: RTL and testbench

COUNTER -- requirements
Module: counter

---
 rtl/counter_pkg.sv | 10 +
 rtl/counter_period_meter.sv | 64 ++++++
 rtl/counter.sv | 72 +++++++
 tb/tb_counter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants for the phase counter / sine period meter.
// Holds default widths and the width of one sine-table sample.
package counter_pkg;

  localparam int QW_DEF = 8;   // phase counter, preload and table-index width
  localparam int DW_DEF = 4;   // step (delta) width
  localparam int FW_DEF = 20;  // period-measurement width
  localparam int SAMP_W = 8;   // offset-binary sine sample width

endpackage

// File: rtl/counter_period_meter.sv
// Period meter for the sine sample stream: detects rising edges of the
// sample MSB (offset-binary sign crossing) and reports the number of
// clocks between consecutive rising edges.
// Optional feature macro: FREQ_SAT_EN -- when defined, the running count
// and the reported period saturate at all-ones instead of wrapping.
module counter_period_meter
  import counter_pkg::*;
#(
  parameter int FW = FW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          samp_msb_i,
  output logic [FW-1:0] freq_o
);

  localparam logic [FW-1:0] CNT_MAX = '1;
  localparam logic [FW-1:0] CNT_ONE = FW'(1);

  logic          msb_d_q;
  logic [FW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;
  logic [FW-1:0] freq_q, freq_d;
  logic          rise;

  // One-clock advance of the period count; saturating or wrapping.
  function automatic logic [FW-1:0] next_count(input logic [FW-1:0] v);
`ifdef FREQ_SAT_EN
    return (v == CNT_MAX) ? v : v + CNT_ONE;
`else
    return v + CNT_ONE;
`endif
  endfunction

  assign rise = samp_msb_i & ~msb_d_q;

  // Next-state: restart the count on every rise; the first rise only arms.
  always_comb begin
    cnt_d   = rise ? '0 : next_count(cnt_q);
    armed_d = armed_q | rise;
    freq_d  = freq_q;
    if (rise && armed_q) begin
      freq_d = next_count(cnt_q);
    end
  end

  // Edge-detect delay, period count and reported period registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      msb_d_q <= 1'b0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      freq_q  <= '0;
    end else begin
      msb_d_q <= samp_msb_i;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      freq_q  <= freq_d;
    end
  end

  assign freq_o = freq_q;

endmodule

// File: rtl/counter.sv
// Up/down phase counter with preload, driving a sine lookup table whose
// registered sample feeds a period meter (clocks per sine cycle).
// sin_table is a ROM loaded from outside by hierarchical reference; it is
// never reset or initialised here.
// Optional feature macro: FREQ_SAT_EN (see counter_period_meter).
module counter
  import counter_pkg::*;
#(
  parameter int QW = QW_DEF,
  parameter int DW = DW_DEF,
  parameter int FW = FW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          preload,
  input  logic          up_dn,
  input  logic [DW-1:0] delta,
  input  logic [QW-1:0] pl_data,
  output logic [QW-1:0] qout,
  output logic [FW-1:0] freq_out
);

  logic [SAMP_W-1:0] sin_table [0:(1<<QW)-1];

  logic [QW-1:0]     qout_q, qout_d;
  logic [QW-1:0]     delta_ext;
  logic [SAMP_W-1:0] samp_q;

  assign delta_ext = QW'(delta);

  // Counter next state: preload wins over counting; wrap is silent.
  always_comb begin
    qout_d = qout_q;
    if (preload) begin
      qout_d = pl_data;
    end else if (up_dn) begin
      qout_d = qout_q + delta_ext;
    end else begin
      qout_d = qout_q - delta_ext;
    end
  end

  // Stage 0: phase counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      qout_q <= '0;
    end else begin
      qout_q <= qout_d;
    end
  end

  // Stage 1: sine sample register, one clock behind the phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      samp_q <= '0;
    end else begin
      samp_q <= sin_table[qout_q];
    end
  end

  counter_period_meter #(
    .FW(FW)
  ) u_meter (
    .clk_i      (clk),
    .rst_i      (reset),
    .samp_msb_i (samp_q[SAMP_W-1]),
    .freq_o     (freq_out)
  );

  assign qout = qout_q;

endmodule

// File: tb/tb_counter.sv
// Testbench for counter: table-driven vectors for counting/preload/wrap,
// hand-written multi-cycle sequences for period measurement, and a
// randomized run against a timestamp-based reference model.
module tb_counter;

  localparam int QW   = 8;
  localparam int DW   = 4;
  localparam int FW   = 12;
  localparam int MAXV = (1 << FW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          preload = 1'b0;
  logic          up_dn = 1'b1;
  logic [DW-1:0] delta = '0;
  logic [QW-1:0] pl_data = '0;
  logic [QW-1:0] qout;
  logic [FW-1:0] freq_out;

  counter #(.QW(QW), .DW(DW), .FW(FW)) dut (
    .clk      (clk),
    .reset    (reset),
    .preload  (preload),
    .up_dn    (up_dn),
    .delta    (delta),
    .pl_data  (pl_data),
    .qout     (qout),
    .freq_out (freq_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit [7:0] tbl [256];
  int  q_m = 0;
  bit  s1 = 0, s2 = 0;       // sample MSB now / one clock earlier
  int  cyc = 0;
  int  last_rise = 0;
  bit  armed_m = 0;
  int  freq_m = 0;

  typedef struct {
    bit r;
    bit pl;
    bit ud;
    int d;
    int pd;
    int exp_q;
  } vec_t;
  vec_t vecs [15];

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int report(input int d);
`ifdef FREQ_SAT_EN
    return (d > MAXV) ? MAXV : d;
`else
    return d % (MAXV + 1);
`endif
  endfunction

  task automatic step(input bit r, input bit pl, input bit ud, input int d, input int pd);
    bit rise;
    reset   = r;
    preload = pl;
    up_dn   = ud;
    delta   = DW'(d);
    pl_data = QW'(pd);
    @(posedge clk);
    cyc++;
    rise = s1 && !s2 && !r;
    if (r) begin
      armed_m = 0;
      freq_m  = 0;
    end else if (rise) begin
      if (armed_m) freq_m = report(cyc - last_rise);
      armed_m   = 1;
      last_rise = cyc;
    end
    s2 = r ? 1'b0 : s1;
    s1 = r ? 1'b0 : tbl[q_m][7];
    if (r)       q_m = 0;
    else if (pl) q_m = pd % 256;
    else if (ud) q_m = (q_m + d) % 256;
    else         q_m = (q_m - d + 256) % 256;
    #1;
    check("qout_model", int'(qout), q_m);
    check("freq_model", int'(freq_out), freq_m);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      tbl[i] = 8'(int'(128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * i / 256.0)));
      dut.sin_table[i] = tbl[i];
    end

    vecs[0]  = '{1, 0, 1,  0, 8'h00, 8'h00};
    vecs[1]  = '{0, 1, 1,  0, 8'hF0, 8'hF0};
    vecs[2]  = '{0, 0, 0,  5, 8'h00, 8'hEB};
    vecs[3]  = '{0, 0, 0,  5, 8'h00, 8'hE6};
    vecs[4]  = '{0, 0, 1,  1, 8'h00, 8'hE7};
    vecs[5]  = '{0, 0, 1,  0, 8'h00, 8'hE7};
    vecs[6]  = '{0, 1, 1, 15, 8'h05, 8'h05};
    vecs[7]  = '{0, 0, 0,  5, 8'h00, 8'h00};
    vecs[8]  = '{0, 0, 0,  5, 8'h00, 8'hFB};
    vecs[9]  = '{0, 0, 1,  4, 8'h00, 8'hFF};
    vecs[10] = '{0, 0, 1,  4, 8'h00, 8'h03};
    vecs[11] = '{1, 1, 1,  0, 8'hAA, 8'h00};
    vecs[12] = '{0, 0, 1, 15, 8'h00, 8'h0F};
    vecs[13] = '{0, 0, 0, 15, 8'h00, 8'h00};
    vecs[14] = '{0, 0, 0,  1, 8'h00, 8'hFF};

    @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      step(vecs[i].r, vecs[i].pl, vecs[i].ud, vecs[i].d, vecs[i].pd);
      check($sformatf("vec%0d_qout", i), int'(qout), vecs[i].exp_q);
      if (i == 0) check("reset_freq", int'(freq_out), 0);
    end

    // Reset 3 clocks, then count up by 1.
    for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 0);
    check("rst3_qout", int'(qout), 0);
    check("rst3_freq", int'(freq_out), 0);
    for (int n = 1; n <= 300; n++) begin
      step(0, 0, 1, 1, 0);
      if (n == 255) check("d1_qout_ff", int'(qout), 255);
      if (n == 256) check("d1_qout_wrap", int'(qout), 0);
      if (n == 200) check("d1_freq_unarmed", int'(freq_out), 0);
    end
    check("d1_freq", int'(freq_out), 256);

    for (int n = 0; n < 400; n++) step(0, 0, 1, 2, 0);
    check("d2_freq", int'(freq_out), 128);
    for (int n = 0; n < 300; n++) step(0, 0, 1, 4, 0);
    check("d4_freq", int'(freq_out), 64);
    for (int n = 0; n < 600; n++) step(0, 0, 1, 3, 0);
    check("d3_freq_85_86", int'(freq_out == 85 || freq_out == 86), 1);
    for (int n = 0; n < 400; n++) step(0, 0, 1, 5, 0);
    check("d5_freq_51_52", int'(freq_out == 51 || freq_out == 52), 1);

    // Long hold with delta=0, then resume: period overflow behaviour.
    for (int n = 0; n < 5000; n++) step(0, 0, 1, 0, 0);
    for (int n = 0; n < 300; n++) step(0, 0, 1, 1, 0);
`ifdef FREQ_SAT_EN
    check("ovf_freq_sat", int'(freq_out), MAXV);
`else
    check("ovf_freq_wrap", int'(freq_out == MAXV), 0);
`endif

    // Reset pulse mid-run discards the measurement; first rise only arms.
    for (int n = 0; n < 100; n++) step(0, 0, 1, 1, 0);
    step(1, 0, 1, 4, 0);
    check("midrst_qout", int'(qout), 0);
    check("midrst_freq", int'(freq_out), 0);
    for (int n = 1; n <= 150; n++) begin
      step(0, 0, 1, 4, 0);
      if (n == 30) check("midrst_unarmed", int'(freq_out), 0);
    end
    check("midrst_freq64", int'(freq_out), 64);

    // Randomized run against the reference model.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom % 200) == 0, ($urandom % 20) == 0, 1'($urandom),
           int'($urandom % 16), int'($urandom % 256));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
